serial_adder_ctrl: RTL and testbench

//  Bit-serial adder built around a single full-adder cell plus a carry flop.

---
 rtl/serial_adder_ctrl.sv | 146 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder: one full-adder cell plus a carry flop, processing one bit
// per clock, LSB first. Operands and carry-in are captured when a start is
// accepted (in IDLE or DONE). After WIDTH RUN cycles the full sum and the
// carry-out are written to the output registers and done_out pulses for one
// cycle. A start seen during that DONE cycle begins the next operation with
// no idle gap.
//
// Ports
//   clk_in    : clock, all state updates on the rising edge
//   rst_in    : synchronous active-high reset, overrides everything
//   start_in  : request; honoured only in IDLE or DONE
//   a_in      : operand A (WIDTH bits), captured on accepted start
//   b_in      : operand B (WIDTH bits), captured on accepted start
//   c_in      : carry-in, captured on accepted start
//   sum_out   : registered sum, holds until the next completion
//   c_out     : registered carry-out, holds until the next completion
//   busy_out  : high while bits are being processed (state RUN)
//   done_out  : one-cycle pulse when sum_out/c_out have just been updated
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic [WIDTH-1:0] a_next, b_next, res_next;
    logic             cy_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;

    logic bit_sum;
    logic carry_next;
    logic accept;
    logic last_bit;

    // Full-adder cell on the current LSBs.
    assign bit_sum    = a_reg[0] ^ b_reg[0] ^ cy_reg;
    assign carry_next = (a_reg[0] & b_reg[0]) | (cy_reg & (a_reg[0] ^ b_reg[0]));

    // A start is only honoured outside RUN, so operands never change mid-add.
    assign accept   = start_in && (state_reg != RUN);
    assign last_bit = (cnt_reg == LAST_BIT);

    // Right-shift lanes: operands shift towards bit 0, the new sum bit enters
    // at the MSB of the result so that after WIDTH shifts bit 0 holds the
    // first (least significant) sum bit.
    assign a_next[WIDTH-1]   = 1'b0;
    assign b_next[WIDTH-1]   = 1'b0;
    assign res_next[WIDTH-1] = bit_sum;

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_next[gi]   = a_reg[gi + 1];
            assign b_next[gi]   = b_reg[gi + 1];
            assign res_next[gi] = res_reg[gi + 1];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_in) state_next = RUN;
            end
            RUN: begin
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                state_next = start_in ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, bit-serial shifting and result update.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cy_reg    <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
        end else if (accept) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            res_reg <= '0;
            cy_reg  <= c_in;
            cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            a_reg   <= a_next;
            b_reg   <= b_next;
            res_reg <= res_next;
            cy_reg  <= carry_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            // Outputs are only touched on the final bit so they hold steady
            // for the whole run.
            if (last_bit) begin
                sum_reg   <= res_next;
                c_out_reg <= carry_next;
            end
        end
    end

    assign sum_out  = sum_reg;
    assign c_out    = c_out_reg;
    assign busy_out = (state_reg == RUN);
    assign done_out = (state_reg == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Directed and randomized checks of serial_adder_ctrl (WIDTH=4) against a
// reference computed with plain integer addition: {c_out,sum} = a+b+c_in.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int WIDTH = 4;

    logic             clk_in;
    logic             rst_in;
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [WIDTH-1:0] sum_out;
    logic             c_out;
    logic             busy_out;
    logic             done_out;

    int vectors;
    int miscompares;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start_in (start_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_in     (c_in),
        .sum_out  (sum_out),
        .c_out    (c_out),
        .busy_out (busy_out),
        .done_out (done_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic sum, WIDTH+1 bits.
    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic c);
        return (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c);
    endfunction

    // One complete operation from IDLE: start, scramble inputs while running,
    // check busy length, latency, result and the single-cycle done pulse.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic c);
        logic [WIDTH:0] exp;
        int n;
        int nbusy;
        exp      = ref_sum(a, b, c);
        a_in     = a;
        b_in     = b;
        c_in     = c;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n     = 0;
        nbusy = 0;
        while (!done_out && n < 20) begin
            if (busy_out) nbusy++;
            a_in = WIDTH'($urandom);
            b_in = WIDTH'($urandom);
            c_in = 1'($urandom);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(WIDTH));
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(WIDTH));
        chk({tag, "_result"}, 32'({c_out, sum_out}), 32'(exp));
        $display("op %s a=%h b=%h c=%b -> sum=%h c_out=%b", tag, a, b, c, sum_out, c_out);
        tick();
        chk({tag, "_done_pulse_end"}, 32'(done_out), 32'd0);
    endtask

    initial begin
        int ndone;
        int n;
        logic [WIDTH-1:0] cap_sum;
        logic             cap_c;

        vectors     = 0;
        miscompares = 0;
        rst_in      = 1'b1;
        start_in    = 1'b0;
        a_in        = '0;
        b_in        = '0;
        c_in        = 1'b0;

        // Reset for two cycles.
        tick();
        tick();
        chk("reset_sum", 32'(sum_out), 32'd0);
        chk("reset_cout", 32'(c_out), 32'd0);
        chk("reset_busy", 32'(busy_out), 32'd0);
        chk("reset_done", 32'(done_out), 32'd0);
        rst_in = 1'b0;
        tick();
        $display("op reset -> sum=%h c_out=%b busy=%b done=%b", sum_out, c_out, busy_out, done_out);

        // Basic and maximum-carry-chain cases.
        do_op("basic", 4'h7, 4'h9, 1'b0);
        do_op("max_carry", 4'hF, 4'hF, 1'b1);

        // Start pulsed again mid-run with different operands must be ignored.
        a_in = 4'h3; b_in = 4'h4; c_in = 1'b0; start_in = 1'b1;
        tick();
        a_in = 4'hF; b_in = 4'hF; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        ndone   = 0;
        cap_sum = '0;
        cap_c   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done_out) begin
                ndone++;
                cap_sum = sum_out;
                cap_c   = c_out;
            end
            tick();
        end
        chk("ignore_busy_done_count", 32'(ndone), 32'd1);
        chk("ignore_busy_sum", 32'(cap_sum), 32'h7);
        chk("ignore_busy_cout", 32'(cap_c), 32'd0);
        $display("op ignore_busy a=3 b=4 c=0 -> sum=%h c_out=%b dones=%0d", cap_sum, cap_c, ndone);

        // Back-to-back: restart in the DONE cycle.
        a_in = 4'h1; b_in = 4'h1; c_in = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n = 0;
        while (!done_out && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_first_latency", 32'(n), 32'(WIDTH));
        chk("b2b_first_result", 32'({c_out, sum_out}), 32'(ref_sum(4'h1, 4'h1, 1'b0)));
        $display("op b2b_first a=1 b=1 c=0 -> sum=%h c_out=%b", sum_out, c_out);
        a_in = 4'hA; b_in = 4'h5; c_in = 1'b1; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk("b2b_no_gap_busy", 32'(busy_out), 32'd1);
        chk("b2b_hold_sum", 32'(sum_out), 32'h2);
        n = 0;
        while (!done_out && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_second_latency", 32'(n), 32'(WIDTH));
        chk("b2b_second_result", 32'({c_out, sum_out}), 32'(ref_sum(4'hA, 4'h5, 1'b1)));
        $display("op b2b_second a=A b=5 c=1 -> sum=%h c_out=%b", sum_out, c_out);
        tick();

        // Reset on the second RUN edge aborts the add with no done pulse.
        a_in = 4'h8; b_in = 4'h8; c_in = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("midrst_sum", 32'(sum_out), 32'd0);
        chk("midrst_cout", 32'(c_out), 32'd0);
        chk("midrst_busy", 32'(busy_out), 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_out) ndone++;
            tick();
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        $display("op mid_reset a=8 b=8 c=0 -> aborted, dones=%0d", ndone);
        do_op("after_reset", 4'h8, 4'h8, 1'b0);

        // Randomized operands.
        for (int i = 0; i < 40; i++) begin
            do_op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        // Exhaustive sweep of all operand combinations.
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    do_op("exhaustive", WIDTH'(a), WIDTH'(b), 1'(c));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
